// File: rtl/memory_pkg.sv
// Shared types and store-lane helpers for the ME stage and its data-memory port.
package memory_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } me_state_t;

  // An encoding of 3 is treated as a word access throughout.
  function automatic logic is_aligned(input mem_size_t size, input logic [1:0] off);
    case (size)
      MEM_B:   return 1'b1;
      MEM_H:   return ~off[0];
      default: return (off == 2'b00);
    endcase
  endfunction

  function automatic logic [WORD_W/8-1:0] be_gen(input mem_size_t size, input logic [1:0] off);
    case (size)
      MEM_B:   return 4'b0001 << off;
      MEM_H:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] replicate(input mem_size_t size, input logic [WORD_W-1:0] d);
    case (size)
      MEM_B:   return {4{d[7:0]}};
      MEM_H:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory req/gnt/rvalid bus between the ME stage (master) and memory (slave).
interface memory_stage_if;
  import memory_pkg::*;

  logic                dmem_req_o;
  logic                dmem_we_o;
  logic [WORD_W-1:0]   dmem_addr_o;
  logic [WORD_W/8-1:0] dmem_be_o;
  logic [WORD_W-1:0]   dmem_wdata_o;
  logic                dmem_gnt_i;
  logic                dmem_rvalid_i;
  logic [WORD_W-1:0]   dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );
endinterface

// File: rtl/memory_stage_load_align.sv
// Selects the addressed byte/half of a load word and sign- or zero-extends it.
module load_align
  import memory_pkg::*;
(
  input  logic [WORD_W-1:0] rdata,
  input  logic [1:0]        off,
  input  mem_size_t         size,
  input  logic              is_unsigned,
  output logic [WORD_W-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{off, 3'b000} +: 8];
    half_v = rdata[{off[1], 4'b0000} +: 16];
    case (size)
      MEM_B:   data = is_unsigned ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      MEM_H:   data = is_unsigned ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// ME pipeline stage: issues loads/stores over the dmem bus, stalls upstream while
// an access is in flight, and registers the retiring instruction into ME->WB.
module memory_stage
  import memory_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic              rf_we_i,
  input  logic [ADDR_W-1:0] rf_waddr_i,
  input  logic              mem_re_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_unsigned_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic              stall_o,
  output logic              misalign_o,
  memory_stage_if.master    dmem,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic              mem2rf_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic [DATA_W-1:0] alu_result_o
);

  me_state_t         state_p0;
  mem_size_t         size;
  logic [1:0]        off;
  logic              aligned, mem_op, access, misalign, retire;
  logic [DATA_W-1:0] ld_data;

  logic              rf_we_p1, mem2rf_p1, misalign_p1;
  logic [ADDR_W-1:0] rf_waddr_p1;
  logic [DATA_W-1:0] mem_rdata_p1, alu_result_p1;

  assign size     = mem_size_t'(mem_size_i);
  assign off      = alu_result_i[1:0];
  assign aligned  = is_aligned(size, off);
  assign mem_op   = valid_i & (mem_re_i | mem_we_i);
  assign access   = mem_op & aligned;
  assign misalign = mem_op & ~aligned;

  // EX holds its inputs while stalled, so the request fields can come straight from them.
  assign dmem.dmem_req_o   = ((state_p0 == IDLE) & access) | (state_p0 == REQ);
  assign dmem.dmem_we_o    = mem_we_i;
  assign dmem.dmem_addr_o  = alu_result_i;
  assign dmem.dmem_be_o    = be_gen(size, off);
  assign dmem.dmem_wdata_o = replicate(size, store_data_i);

  assign stall_o = ((state_p0 == IDLE) & access) | (state_p0 == REQ) |
                   ((state_p0 == RESP) & ~dmem.dmem_rvalid_i);

  // Misaligned memory ops fall into the non-access IDLE path and retire at once.
  assign retire = ((state_p0 == IDLE) & valid_i & ~access) |
                  ((state_p0 == RESP) & dmem.dmem_rvalid_i);

  load_align u_load_align (
    .rdata       (dmem.dmem_rdata_i),
    .off         (off),
    .size        (size),
    .is_unsigned (mem_unsigned_i),
    .data        (ld_data)
  );

  // Stage p0: access FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
    end else begin
      case (state_p0)
        IDLE:    if (access) state_p0 <= dmem.dmem_gnt_i ? RESP : REQ;
        REQ:     if (dmem.dmem_gnt_i) state_p0 <= RESP;
        RESP:    if (dmem.dmem_rvalid_i) state_p0 <= IDLE;
        default: state_p0 <= IDLE;
      endcase
    end
  end

  // Stage p1: ME->WB register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_p1      <= 1'b0;
      rf_waddr_p1   <= '0;
      mem2rf_p1     <= 1'b0;
      mem_rdata_p1  <= '0;
      alu_result_p1 <= '0;
      misalign_p1   <= 1'b0;
    end else begin
      rf_we_p1    <= retire & rf_we_i & valid_i & (rf_waddr_i != '0) & ~misalign;
      mem2rf_p1   <= retire & mem_re_i & ~misalign;
      misalign_p1 <= retire & misalign;
      if (retire) begin
        rf_waddr_p1   <= rf_waddr_i;
        mem_rdata_p1  <= ld_data;
        alu_result_p1 <= alu_result_i;
      end
    end
  end

  assign rf_we_o      = rf_we_p1;
  assign rf_waddr_o   = rf_waddr_p1;
  assign mem2rf_o     = mem2rf_p1;
  assign mem_rdata_o  = mem_rdata_p1;
  assign alu_result_o = alu_result_p1;
  assign misalign_o   = misalign_p1;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: ALU pass-through, loads, stores, misalignment, reset.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, rf_we_i, mem_re_i, mem_we_i, mem_unsigned_i;
  logic [4:0]  rf_waddr_i;
  logic [1:0]  mem_size_i;
  logic [31:0] alu_result_i, store_data_i;
  logic        stall_o, misalign_o, rf_we_o, mem2rf_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] mem_rdata_o, alu_result_o;

  int tests = 0;
  int fails = 0;

  memory_stage_if dmem ();

  memory_stage #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_i        (valid_i),
    .rf_we_i        (rf_we_i),
    .rf_waddr_i     (rf_waddr_i),
    .mem_re_i       (mem_re_i),
    .mem_we_i       (mem_we_i),
    .mem_size_i     (mem_size_i),
    .mem_unsigned_i (mem_unsigned_i),
    .alu_result_i   (alu_result_i),
    .store_data_i   (store_data_i),
    .stall_o        (stall_o),
    .misalign_o     (misalign_o),
    .dmem           (dmem),
    .rf_we_o        (rf_we_o),
    .rf_waddr_o     (rf_waddr_o),
    .mem2rf_o       (mem2rf_o),
    .mem_rdata_o    (mem_rdata_o),
    .alu_result_o   (alu_result_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 0; rf_we_i = 0; rf_waddr_i = 0; mem_re_i = 0; mem_we_i = 0;
    mem_size_i = 0; mem_unsigned_i = 0; alu_result_i = 0; store_data_i = 0;
    dmem.dmem_gnt_i = 0; dmem.dmem_rvalid_i = 0; dmem.dmem_rdata_i = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    #12;
    tests++; if (rf_we_o !== 1'b0) begin fails++; $display("FAIL reset_rf_we: got %b want 0", rf_we_o); end
    tests++; if (rf_waddr_o !== 5'd0) begin fails++; $display("FAIL reset_waddr: got %0d want 0", rf_waddr_o); end
    tests++; if (mem2rf_o !== 1'b0) begin fails++; $display("FAIL reset_mem2rf: got %b want 0", mem2rf_o); end
    tests++; if (mem_rdata_o !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", mem_rdata_o); end
    tests++; if (alu_result_o !== 32'h0) begin fails++; $display("FAIL reset_alu: got %h want 0", alu_result_o); end
    tests++; if (misalign_o !== 1'b0) begin fails++; $display("FAIL reset_misalign: got %b want 0", misalign_o); end
    tests++; if ({stall_o, dmem.dmem_req_o} !== 2'b00) begin fails++; $display("FAIL reset_stall_req: got %b want 00", {stall_o, dmem.dmem_req_o}); end
    step();
    rst_n = 1;
  endtask

  task automatic test_alu();
    step();
    valid_i = 1; rf_we_i = 1; rf_waddr_i = 5; alu_result_i = 32'h0000_1234;
    #1;
    tests++; if (dmem.dmem_req_o !== 1'b0) begin fails++; $display("FAIL alu_req: got %b want 0", dmem.dmem_req_o); end
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL alu_stall: got %b want 0", stall_o); end
    step();
    idle_inputs();
    tests++; if (rf_we_o !== 1'b1) begin fails++; $display("FAIL alu_rf_we: got %b want 1", rf_we_o); end
    tests++; if (rf_waddr_o !== 5'd5) begin fails++; $display("FAIL alu_waddr: got %0d want 5", rf_waddr_o); end
    tests++; if (alu_result_o !== 32'h1234) begin fails++; $display("FAIL alu_result: got %h want 00001234", alu_result_o); end
    tests++; if (mem2rf_o !== 1'b0) begin fails++; $display("FAIL alu_mem2rf: got %b want 0", mem2rf_o); end
    step();
    tests++; if (rf_we_o !== 1'b0) begin fails++; $display("FAIL alu_bubble: got %b want 0", rf_we_o); end
  endtask

  task automatic test_lb();
    valid_i = 1; rf_we_i = 1; rf_waddr_i = 7; mem_re_i = 1; mem_size_i = 0;
    mem_unsigned_i = 0; alu_result_i = 32'h103; dmem.dmem_gnt_i = 1;
    #1;
    tests++; if ({dmem.dmem_req_o, dmem.dmem_we_o, stall_o} !== 3'b101) begin fails++; $display("FAIL lb_req_we_stall: got %b want 101", {dmem.dmem_req_o, dmem.dmem_we_o, stall_o}); end
    tests++; if (dmem.dmem_addr_o !== 32'h103) begin fails++; $display("FAIL lb_addr: got %h want 00000103", dmem.dmem_addr_o); end
    step();
    dmem.dmem_gnt_i = 0; dmem.dmem_rvalid_i = 1; dmem.dmem_rdata_i = 32'h80FF_FF7F;
    #1;
    tests++; if ({dmem.dmem_req_o, stall_o} !== 2'b00) begin fails++; $display("FAIL lb_resp_req_stall: got %b want 00", {dmem.dmem_req_o, stall_o}); end
    tests++; if (mem2rf_o !== 1'b0) begin fails++; $display("FAIL lb_early_retire: got %b want 0", mem2rf_o); end
    step();
    idle_inputs();
    tests++; if ({rf_we_o, mem2rf_o} !== 2'b11) begin fails++; $display("FAIL lb_we_mem2rf: got %b want 11", {rf_we_o, mem2rf_o}); end
    tests++; if (mem_rdata_o !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_rdata: got %h want ffffff80", mem_rdata_o); end
    tests++; if (rf_waddr_o !== 5'd7) begin fails++; $display("FAIL lb_waddr: got %0d want 7", rf_waddr_o); end
  endtask

  task automatic test_sh();
    step();
    valid_i = 1; mem_we_i = 1; mem_size_i = 1; alu_result_i = 32'h102; store_data_i = 32'hABCD_1234;
    for (int c = 0; c < 4; c++) begin
      dmem.dmem_gnt_i = (c == 3);
      #1;
      tests++; if ({dmem.dmem_req_o, dmem.dmem_we_o, stall_o} !== 3'b111) begin fails++; $display("FAIL sh_req_c%0d: got %b want 111", c, {dmem.dmem_req_o, dmem.dmem_we_o, stall_o}); end
      tests++; if (dmem.dmem_be_o !== 4'b1100) begin fails++; $display("FAIL sh_be_c%0d: got %b want 1100", c, dmem.dmem_be_o); end
      tests++; if (dmem.dmem_wdata_o !== 32'h1234_1234) begin fails++; $display("FAIL sh_wdata_c%0d: got %h want 12341234", c, dmem.dmem_wdata_o); end
      tests++; if (dmem.dmem_addr_o !== 32'h102) begin fails++; $display("FAIL sh_addr_c%0d: got %h want 00000102", c, dmem.dmem_addr_o); end
      step();
    end
    dmem.dmem_gnt_i = 0;
    #1;
    tests++; if ({dmem.dmem_req_o, stall_o} !== 2'b01) begin fails++; $display("FAIL sh_wait_resp: got %b want 01", {dmem.dmem_req_o, stall_o}); end
    step();
    dmem.dmem_rvalid_i = 1;
    #1;
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL sh_ack_stall: got %b want 0", stall_o); end
    step();
    idle_inputs();
    tests++; if ({rf_we_o, mem2rf_o} !== 2'b00) begin fails++; $display("FAIL sh_retire_we: got %b want 00", {rf_we_o, mem2rf_o}); end
    tests++; if (alu_result_o !== 32'h102) begin fails++; $display("FAIL sh_retire_alu: got %h want 00000102", alu_result_o); end
  endtask

  task automatic test_misalign();
    valid_i = 1; rf_we_i = 1; rf_waddr_i = 3; mem_re_i = 1; mem_size_i = 2; alu_result_i = 32'h101;
    #1;
    tests++; if ({dmem.dmem_req_o, stall_o, misalign_o} !== 3'b000) begin fails++; $display("FAIL mis_req_stall: got %b want 000", {dmem.dmem_req_o, stall_o, misalign_o}); end
    step();
    idle_inputs();
    tests++; if ({misalign_o, rf_we_o, mem2rf_o} !== 3'b100) begin fails++; $display("FAIL mis_flag: got %b want 100", {misalign_o, rf_we_o, mem2rf_o}); end
    tests++; if (alu_result_o !== 32'h101) begin fails++; $display("FAIL mis_retire_alu: got %h want 00000101", alu_result_o); end
    step();
    tests++; if (misalign_o !== 1'b0) begin fails++; $display("FAIL mis_one_cycle: got %b want 0", misalign_o); end
  endtask

  task automatic test_reset_mid();
    valid_i = 1; rf_we_i = 1; rf_waddr_i = 6; mem_re_i = 1; mem_size_i = 2; alu_result_i = 32'h200;
    dmem.dmem_gnt_i = 1;
    step();
    dmem.dmem_gnt_i = 0;
    #1;
    tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL rst_in_resp_stall: got %b want 1", stall_o); end
    rst_n = 0;
    idle_inputs();
    #1;
    tests++; if ({alu_result_o, mem_rdata_o} !== 64'h0) begin fails++; $display("FAIL rst_mid_outputs: got %h want 0", {alu_result_o, mem_rdata_o}); end
    tests++; if ({stall_o, dmem.dmem_req_o} !== 2'b00) begin fails++; $display("FAIL rst_mid_stall: got %b want 00", {stall_o, dmem.dmem_req_o}); end
    step();
    rst_n = 1;
    valid_i = 1; rf_we_i = 1; rf_waddr_i = 4; mem_re_i = 1; mem_size_i = 2; alu_result_i = 32'h300;
    dmem.dmem_rvalid_i = 1; dmem.dmem_rdata_i = 32'hDEAD_BEEF;
    #1;
    tests++; if ({dmem.dmem_req_o, stall_o} !== 2'b11) begin fails++; $display("FAIL rst_late_idle_req: got %b want 11", {dmem.dmem_req_o, stall_o}); end
    step();
    dmem.dmem_rvalid_i = 0;
    tests++; if ({rf_we_o, mem2rf_o} !== 2'b00) begin fails++; $display("FAIL rst_late_rvalid: got %b want 00", {rf_we_o, mem2rf_o}); end
    dmem.dmem_gnt_i = 1;
    step();
    dmem.dmem_gnt_i = 0; dmem.dmem_rvalid_i = 1; dmem.dmem_rdata_i = 32'h1357_9BDF;
    step();
    idle_inputs();
    tests++; if (mem_rdata_o !== 32'h1357_9BDF) begin fails++; $display("FAIL rst_after_lw: got %h want 13579bdf", mem_rdata_o); end
    tests++; if ({rf_we_o, rf_waddr_o} !== {1'b1, 5'd4}) begin fails++; $display("FAIL rst_after_lw_we: got %b/%0d want 1/4", rf_we_o, rf_waddr_o); end
  endtask

  task automatic test_back_to_back();
    valid_i = 1; rf_we_i = 1; rf_waddr_i = 0; mem_re_i = 1; mem_size_i = 1; mem_unsigned_i = 1;
    alu_result_i = 32'h102; dmem.dmem_gnt_i = 1;
    step();
    dmem.dmem_gnt_i = 0; dmem.dmem_rvalid_i = 1; dmem.dmem_rdata_i = 32'h8001_0000;
    step();
    dmem.dmem_rvalid_i = 0;
    rf_waddr_i = 9; mem_size_i = 0; mem_unsigned_i = 0; alu_result_i = 32'h100;
    #1;
    tests++; if ({rf_we_o, mem2rf_o} !== 2'b01) begin fails++; $display("FAIL b2b_x0_we: got %b want 01", {rf_we_o, mem2rf_o}); end
    tests++; if (mem_rdata_o !== 32'h0000_8001) begin fails++; $display("FAIL b2b_lhu_rdata: got %h want 00008001", mem_rdata_o); end
    tests++; if ({dmem.dmem_req_o, dmem.dmem_be_o} !== 5'b1_0001) begin fails++; $display("FAIL b2b_second_req: got %b want 10001", {dmem.dmem_req_o, dmem.dmem_be_o}); end
    dmem.dmem_gnt_i = 1;
    step();
    dmem.dmem_gnt_i = 0; dmem.dmem_rvalid_i = 1; dmem.dmem_rdata_i = 32'h0000_00F0;
    step();
    idle_inputs();
    tests++; if (mem_rdata_o !== 32'hFFFF_FFF0) begin fails++; $display("FAIL b2b_lb_rdata: got %h want fffffff0", mem_rdata_o); end
    tests++; if ({rf_we_o, rf_waddr_o} !== {1'b1, 5'd9}) begin fails++; $display("FAIL b2b_lb_we: got %b/%0d want 1/9", rf_we_o, rf_waddr_o); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb();
    test_sh();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
